// File: rtl/lapido_defs.sv
// rtl/lapido_defs.sv - shared opcode, funct, select constants and control-word layout
package lapido_defs;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_LOAD    = 6'h01;
    localparam logic [5:0] OP_STORE   = 6'h02;
    localparam logic [5:0] OP_J_TYPE  = 6'h03;
    localparam logic [5:0] OP_JAL     = 6'h04;
    localparam logic [5:0] OP_BEQ     = 6'h05;
    localparam logic [5:0] OP_BNE     = 6'h06;
    localparam logic [5:0] OP_JT      = 6'h07;
    localparam logic [5:0] OP_JF      = 6'h08;
    localparam logic [5:0] OP_LOADLIT = 6'h09;
    localparam logic [5:0] OP_ADDI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0B;
    localparam logic [5:0] OP_ORI     = 6'h0C;
    localparam logic [5:0] OP_SLTI    = 6'h0D;
    localparam logic [5:0] OP_LCL     = 6'h0E;
    localparam logic [5:0] OP_LCH     = 6'h0F;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_LCL = 6'h30;
    localparam logic [5:0] FN_LCH = 6'h31;

    localparam logic SEL_JR  = 1'b0;
    localparam logic SEL_J   = 1'b1;
    localparam logic SEL_BEQ = 1'b0;
    localparam logic SEL_BNE = 1'b1;
    localparam logic SEL_JF  = 1'b0;
    localparam logic SEL_JT  = 1'b1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] REG_DST_RT   = 2'd0;
    localparam logic [1:0] REG_DST_RD   = 2'd1;
    localparam logic [1:0] REG_DST_LINK = 2'd2;

    localparam logic ALU_SRC_IMM = 1'b0;
    localparam logic ALU_SRC_REG = 1'b1;

    // Control word is nested so each later stage keeps only its own sub-slice.
    typedef struct packed {
        logic       reg_write_enable;
        logic [1:0] res_mux;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_write_enable;
        logic     sel_beq_bne;
        logic     fl_write_enable;
        logic     sel_jt_jf;
        logic     is_branch;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    typedef struct packed {
        logic      alu_src;
        logic      sel_j_jr;
        logic      is_jump;
        logic      is_load;
        mem_ctrl_t mem;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// rtl/ctrl_pipeline_if.sv - ID-side inputs and per-stage control outputs of the control pipeline
interface ctrl_pipeline_if #(
    parameter int FN_W  = 6,
    parameter int REG_W = 4
);
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [5:0]       id_funct;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             ex_stall;
    logic             flush;

    logic             id_stall;
    logic             illegal_op;
    logic             ex_valid;
    logic             ex_alu_src;
    logic             ex_sel_j_jr;
    logic             ex_is_jump;
    logic             ex_is_load;
    logic [FN_W-1:0]  ex_alu_funct;
    logic [REG_W-1:0] ex_dst_reg;
    logic             mem_valid;
    logic             mem_write_enable;
    logic             mem_sel_beq_bne;
    logic             mem_fl_write_enable;
    logic             mem_sel_jt_jf;
    logic             mem_is_branch;
    logic             wb_valid;
    logic             wb_reg_write_enable;
    logic [1:0]       wb_res_mux;
    logic [REG_W-1:0] wb_dst_reg;

    modport master (
        output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, ex_stall, flush,
        input  id_stall, illegal_op,
        input  ex_valid, ex_alu_src, ex_sel_j_jr, ex_is_jump, ex_is_load, ex_alu_funct, ex_dst_reg,
        input  mem_valid, mem_write_enable, mem_sel_beq_bne, mem_fl_write_enable, mem_sel_jt_jf, mem_is_branch,
        input  wb_valid, wb_reg_write_enable, wb_res_mux, wb_dst_reg
    );

    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, ex_stall, flush,
        output id_stall, illegal_op,
        output ex_valid, ex_alu_src, ex_sel_j_jr, ex_is_jump, ex_is_load, ex_alu_funct, ex_dst_reg,
        output mem_valid, mem_write_enable, mem_sel_beq_bne, mem_fl_write_enable, mem_sel_jt_jf, mem_is_branch,
        output wb_valid, wb_reg_write_enable, wb_res_mux, wb_dst_reg
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct decode into a control word and destination register
module ctrl_decode
    import lapido_defs::*;
#(
    parameter int FN_W     = 6,
    parameter int REG_W    = 4,
    parameter int LINK_REG = 15
) (
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output ctrl_word_t       ctrl,
    output logic [FN_W-1:0]  alu_funct,
    output logic [REG_W-1:0] dst_reg,
    output logic             rs_used,
    output logic             rt_used,
    output logic             illegal
);

    logic [1:0] dst_sel;

    // Opcode decode; every field starts at its inactive default so no path leaves one open.
    always_comb begin
        ctrl            = '0;
        ctrl.alu_src    = ALU_SRC_IMM;
        ctrl.mem.wb.res_mux = WB_ALU;
        alu_funct       = '0;
        dst_sel         = REG_DST_RT;
        rs_used         = 1'b1;
        rt_used         = 1'b0;
        illegal         = 1'b0;
        case (opcode)
            OP_STORE: begin
                ctrl.mem.mem_write_enable = 1'b1;
                rt_used                   = 1'b1;
            end
            OP_LOAD: begin
                ctrl.mem.wb.res_mux          = WB_MEM;
                ctrl.mem.wb.reg_write_enable = 1'b1;
                ctrl.is_load                 = 1'b1;
            end
            OP_J_TYPE: begin
                ctrl.is_jump  = 1'b1;
                ctrl.sel_j_jr = SEL_J;
                rs_used       = 1'b0;
            end
            OP_JAL: begin
                ctrl.is_jump                 = 1'b1;
                ctrl.sel_j_jr                = SEL_J;
                ctrl.mem.wb.res_mux          = WB_PC;
                ctrl.mem.wb.reg_write_enable = 1'b1;
                dst_sel                      = REG_DST_LINK;
                rs_used                      = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.mem.is_branch   = 1'b1;
                ctrl.alu_src         = ALU_SRC_REG;
                alu_funct            = FN_W'(FN_SUB);
                ctrl.mem.sel_beq_bne = (opcode == OP_BEQ) ? SEL_BEQ : SEL_BNE;
                rt_used              = 1'b1;
            end
            OP_JT, OP_JF: begin
                ctrl.mem.is_branch = 1'b1;
                ctrl.mem.sel_jt_jf = (opcode == OP_JT) ? SEL_JT : SEL_JF;
                rs_used            = 1'b0;
            end
            OP_LOADLIT: begin
                ctrl.mem.wb.res_mux          = WB_IMM;
                ctrl.mem.wb.reg_write_enable = 1'b1;
                rs_used                      = 1'b0;
            end
            OP_RTYPE: begin
                dst_sel      = REG_DST_RD;
                ctrl.alu_src = ALU_SRC_REG;
                rt_used      = 1'b1;
                if (funct == FN_JR) begin
                    ctrl.is_jump  = 1'b1;
                    ctrl.sel_j_jr = SEL_JR;
                end else begin
                    alu_funct                    = FN_W'(funct);
                    ctrl.mem.wb.reg_write_enable = 1'b1;
                    ctrl.mem.fl_write_enable     = 1'b1;
                end
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LCL, OP_LCH: begin
                ctrl.mem.wb.reg_write_enable = 1'b1;
                ctrl.mem.fl_write_enable     = 1'b1;
                case (opcode)
                    OP_ADDI: alu_funct = FN_W'(FN_ADD);
                    OP_ANDI: alu_funct = FN_W'(FN_AND);
                    OP_ORI:  alu_funct = FN_W'(FN_OR);
                    OP_SLTI: alu_funct = FN_W'(FN_SLT);
                    OP_LCL:  alu_funct = FN_W'(FN_LCL);
                    default: alu_funct = FN_W'(FN_LCH);
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    // Resolve the destination select into an actual register number.
    always_comb begin
        dst_reg = rt;
        case (dst_sel)
            REG_DST_RD:   dst_reg = rd;
            REG_DST_LINK: dst_reg = REG_W'(LINK_REG);
            default:      dst_reg = rt;
        endcase
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - EX/MEM/WB control slices with stall, flush, load-use hazard and sticky illegal flag
module ctrl_pipeline
    import lapido_defs::*;
#(
    parameter int FN_W      = 6,
    parameter int REG_W     = 4,
    parameter int LINK_REG  = 15,
    parameter int HAZARD_EN = 1
) (
    input logic           clk,
    input logic           rst_n,
    ctrl_pipeline_if.slave bus
);

    ctrl_word_t       dec_ctrl;
    logic [FN_W-1:0]  dec_alu_funct;
    logic [REG_W-1:0] dec_dst;
    logic             dec_rs_used;
    logic             dec_rt_used;
    logic             dec_illegal;

    logic             ex_valid;
    ctrl_word_t       ex_ctrl;
    logic [FN_W-1:0]  ex_alu_funct;
    logic [REG_W-1:0] ex_dst;

    logic             mem_valid;
    mem_ctrl_t        mem_ctrl;
    logic [REG_W-1:0] mem_dst;

    logic             wb_valid;
    wb_ctrl_t         wb_ctrl;
    logic [REG_W-1:0] wb_dst;

    logic             illegal_q;
    logic             id_stall;
    logic             reg_hit;
    logic             advance;
    logic             take_id;

    ctrl_decode #(
        .FN_W     (FN_W),
        .REG_W    (REG_W),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .opcode    (bus.id_opcode),
        .funct     (bus.id_funct),
        .rt        (bus.id_rt),
        .rd        (bus.id_rd),
        .ctrl      (dec_ctrl),
        .alu_funct (dec_alu_funct),
        .dst_reg   (dec_dst),
        .rs_used   (dec_rs_used),
        .rt_used   (dec_rt_used),
        .illegal   (dec_illegal)
    );

    // Load-use detection: a load in EX whose destination feeds a source the ID instruction reads.
    always_comb begin
        reg_hit  = (dec_rs_used && (bus.id_rs == ex_dst)) ||
                   (dec_rt_used && (bus.id_rt == ex_dst));
        id_stall = (HAZARD_EN != 0) && bus.id_valid && ex_valid && ex_ctrl.is_load &&
                   !bus.flush && reg_hit;
        advance  = !bus.flush && !bus.ex_stall;
        take_id  = bus.id_valid && !dec_illegal && !id_stall;
    end

    // EX slice: flush kills it, stall holds it, otherwise it takes the decode or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= '0;
            ex_alu_funct <= '0;
            ex_dst       <= '0;
        end else if (bus.flush || (advance && !take_id)) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= '0;
            ex_alu_funct <= '0;
            ex_dst       <= '0;
        end else if (advance) begin
            ex_valid     <= 1'b1;
            ex_ctrl      <= dec_ctrl;
            ex_alu_funct <= dec_alu_funct;
            ex_dst       <= dec_dst;
        end
    end

    // MEM slice: flush kills it, otherwise it follows EX unless stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_dst   <= '0;
        end else if (bus.flush) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_dst   <= '0;
        end else if (!bus.ex_stall) begin
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl.mem;
            mem_dst   <= ex_dst;
        end
    end

    // WB slice: the instruction in MEM is older than the flushing one, so it still retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_ctrl  <= '0;
            wb_dst   <= '0;
        end else if (bus.flush || !bus.ex_stall) begin
            wb_valid <= mem_valid;
            wb_ctrl  <= mem_ctrl.wb;
            wb_dst   <= mem_dst;
        end
    end

    // Sticky illegal flag, set only on an edge that actually captures the ID instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (advance && bus.id_valid && dec_illegal && !id_stall) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.id_stall            = id_stall;
    assign bus.illegal_op          = illegal_q;
    assign bus.ex_valid            = ex_valid;
    assign bus.ex_alu_src          = ex_ctrl.alu_src;
    assign bus.ex_sel_j_jr         = ex_ctrl.sel_j_jr;
    assign bus.ex_is_jump          = ex_ctrl.is_jump;
    assign bus.ex_is_load          = ex_ctrl.is_load;
    assign bus.ex_alu_funct        = ex_alu_funct;
    assign bus.ex_dst_reg          = ex_dst;
    assign bus.mem_valid           = mem_valid;
    assign bus.mem_write_enable    = mem_ctrl.mem_write_enable;
    assign bus.mem_sel_beq_bne     = mem_ctrl.sel_beq_bne;
    assign bus.mem_fl_write_enable = mem_ctrl.fl_write_enable;
    assign bus.mem_sel_jt_jf       = mem_ctrl.sel_jt_jf;
    assign bus.mem_is_branch       = mem_ctrl.is_branch;
    assign bus.wb_valid            = wb_valid;
    assign bus.wb_reg_write_enable = wb_ctrl.reg_write_enable;
    assign bus.wb_res_mux          = wb_ctrl.res_mux;
    assign bus.wb_dst_reg          = wb_dst;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - scoreboard bench for the control pipeline
module tb_ctrl_pipeline;
    import lapido_defs::*;

    typedef struct {
        logic       we;
        logic [1:0] mux;
        logic [3:0] dst;
    } wb_exp_t;

    logic    clk = 1'b0;
    logic    rst_n;
    wb_exp_t sb[$];
    wb_exp_t e;
    int      pass_cnt = 0;
    int      total_cnt = 0;

    always #5 clk = ~clk;

    ctrl_pipeline_if #(.FN_W(6), .REG_W(4)) bus ();

    ctrl_pipeline #(
        .FN_W      (6),
        .REG_W     (4),
        .LINK_REG  (15),
        .HAZARD_EN (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic wb_exp_t mk(input logic we, input logic [1:0] mux, input logic [3:0] dst);
        wb_exp_t r;
        r.we = we; r.mux = mux; r.dst = dst;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
        bus.id_valid = 1'b1; bus.id_opcode = op; bus.id_funct = fn;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    endtask

    task automatic idle();
        bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_funct = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    endtask

    task automatic test_reset();
        idle(); bus.ex_stall = 1'b0; bus.flush = 1'b0; rst_n = 1'b0;
        repeat (2) tick();
        total_cnt++; if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.illegal_op, bus.id_stall} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.illegal_op, bus.id_stall}); else pass_cnt++;
        total_cnt++; if ({bus.ex_alu_funct, bus.ex_dst_reg, bus.wb_dst_reg, bus.wb_res_mux, bus.wb_reg_write_enable, bus.mem_write_enable} !== '0)
            $display("FAIL reset_fields: got %0h expected 0", {bus.ex_alu_funct, bus.ex_dst_reg, bus.wb_dst_reg, bus.wb_res_mux, bus.wb_reg_write_enable, bus.mem_write_enable}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        drive(OP_ADDI, 6'h0, 4'd1, 4'd3, 4'd0); sb.push_back(mk(1'b1, WB_ALU, 4'd3));
        tick();
        total_cnt++; if (bus.ex_valid !== 1'b1) $display("FAIL addi_ex_valid: got %b expected 1", bus.ex_valid); else pass_cnt++;
        total_cnt++; if (bus.ex_alu_funct !== FN_ADD) $display("FAIL addi_funct: got %0h expected %0h", bus.ex_alu_funct, FN_ADD); else pass_cnt++;
        total_cnt++; if (bus.ex_dst_reg !== 4'd3) $display("FAIL addi_ex_dst: got %0d expected 3", bus.ex_dst_reg); else pass_cnt++;
        total_cnt++; if (bus.ex_alu_src !== ALU_SRC_IMM) $display("FAIL addi_alu_src: got %b expected %b", bus.ex_alu_src, ALU_SRC_IMM); else pass_cnt++;
        idle();
        tick();
        total_cnt++; if ({bus.mem_valid, bus.mem_fl_write_enable} !== 2'b11) $display("FAIL addi_mem: got %b expected 11", {bus.mem_valid, bus.mem_fl_write_enable}); else pass_cnt++;
        tick();
        total_cnt++; if (bus.wb_valid !== 1'b1) $display("FAIL addi_wb_valid: got %b expected 1", bus.wb_valid); else pass_cnt++;
        if (bus.wb_valid && sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                $display("FAIL addi_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
        end
        sb.delete();
    endtask

    task automatic test_load_use();
        int arrive = 0;
        drive(OP_LOAD, 6'h0, 4'd1, 4'd5, 4'd0); sb.push_back(mk(1'b1, WB_MEM, 4'd5));
        tick();
        drive(OP_RTYPE, FN_ADD, 4'd5, 4'd2, 4'd7); sb.push_back(mk(1'b1, WB_ALU, 4'd7));
        #1;
        total_cnt++; if (bus.id_stall !== 1'b1) $display("FAIL ld_use_stall: got %b expected 1", bus.id_stall); else pass_cnt++;
        for (int k = 1; k <= 8 && sb.size() > 0; k++) begin
            tick();
            if (k == 1) begin
                total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL ld_use_bubble: got %b expected 0", bus.ex_valid); else pass_cnt++;
                total_cnt++; if (bus.id_stall !== 1'b0) $display("FAIL ld_use_stall_once: got %b expected 0", bus.id_stall); else pass_cnt++;
            end
            if (k == 2) idle();
            if (bus.wb_valid) begin
                e = sb.pop_front();
                if (e.dst == 4'd7) arrive = k;
                total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                    $display("FAIL ld_use_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
            end
        end
        total_cnt++; if (sb.size() != 0) $display("FAIL ld_use_drain: got %0d pending expected 0", sb.size()); else pass_cnt++;
        total_cnt++; if (arrive != 4) $display("FAIL ld_use_latency: got %0d expected 4", arrive); else pass_cnt++;
        sb.delete(); idle();
    endtask

    task automatic test_no_hazard();
        drive(OP_LOAD, 6'h0, 4'd1, 4'd5, 4'd0); sb.push_back(mk(1'b1, WB_MEM, 4'd5));
        tick();
        drive(OP_LOADLIT, 6'h0, 4'd5, 4'd5, 4'd0); sb.push_back(mk(1'b1, WB_IMM, 4'd5));
        #1;
        total_cnt++; if (bus.id_stall !== 1'b0) $display("FAIL loadlit_stall: got %b expected 0", bus.id_stall); else pass_cnt++;
        tick();
        idle();
        total_cnt++; if (bus.ex_valid !== 1'b1) $display("FAIL loadlit_ex_valid: got %b expected 1", bus.ex_valid); else pass_cnt++;
        for (int k = 0; k < 8 && sb.size() > 0; k++) begin
            tick();
            if (bus.wb_valid) begin
                e = sb.pop_front();
                total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                    $display("FAIL loadlit_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
            end
        end
        total_cnt++; if (sb.size() != 0) $display("FAIL loadlit_drain: got %0d pending expected 0", sb.size()); else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_stall();
        drive(OP_ADDI, 6'h0, 4'd0, 4'd6, 4'd0); sb.push_back(mk(1'b1, WB_ALU, 4'd6));
        tick();
        bus.ex_stall = 1'b1;
        drive(OP_ORI, 6'h0, 4'd0, 4'd9, 4'd0);
        repeat (2) tick();
        total_cnt++; if ({bus.ex_valid, bus.ex_dst_reg} !== {1'b1, 4'd6}) $display("FAIL stall_hold_ex: got %0h expected 16", {bus.ex_valid, bus.ex_dst_reg}); else pass_cnt++;
        total_cnt++; if (bus.mem_valid !== 1'b0) $display("FAIL stall_hold_mem: got %b expected 0", bus.mem_valid); else pass_cnt++;
        bus.ex_stall = 1'b0;
        idle();
        for (int k = 0; k < 8 && sb.size() > 0; k++) begin
            tick();
            if (bus.wb_valid) begin
                e = sb.pop_front();
                total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                    $display("FAIL stall_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
            end
        end
        total_cnt++; if (sb.size() != 0) $display("FAIL stall_drain: got %0d pending expected 0", sb.size()); else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_flush();
        drive(OP_ADDI, 6'h0, 4'd0, 4'd1, 4'd0); sb.push_back(mk(1'b1, WB_ALU, 4'd1));
        tick();
        drive(OP_ORI, 6'h0, 4'd0, 4'd2, 4'd0); sb.push_back(mk(1'b1, WB_ALU, 4'd2));
        tick();
        drive(OP_STORE, 6'h0, 4'd3, 4'd4, 4'd0);
        tick();
        total_cnt++; if ({bus.ex_valid, bus.mem_valid, bus.wb_valid} !== 3'b111) $display("FAIL flush_inflight: got %b expected 111", {bus.ex_valid, bus.mem_valid, bus.wb_valid}); else pass_cnt++;
        if (bus.wb_valid && sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++; if (bus.wb_dst_reg !== e.dst) $display("FAIL flush_pre_wb: got %0d expected %0d", bus.wb_dst_reg, e.dst); else pass_cnt++;
        end
        idle();
        bus.flush = 1'b1; bus.ex_stall = 1'b1;
        tick();
        total_cnt++; if ({bus.ex_valid, bus.mem_valid} !== 2'b00) $display("FAIL flush_kill: got %b expected 00", {bus.ex_valid, bus.mem_valid}); else pass_cnt++;
        total_cnt++; if (bus.wb_valid !== 1'b1) $display("FAIL flush_wb_valid: got %b expected 1", bus.wb_valid); else pass_cnt++;
        if (bus.wb_valid && sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                $display("FAIL flush_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
        end
        bus.flush = 1'b0; bus.ex_stall = 1'b0;
        tick();
        total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL flush_wb_bubble: got %b expected 0", bus.wb_valid); else pass_cnt++;
        total_cnt++; if (sb.size() != 0) $display("FAIL flush_drain: got %0d pending expected 0", sb.size()); else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_illegal();
        drive(6'h3F, 6'h0, 4'd0, 4'd0, 4'd0);
        tick();
        total_cnt++; if (bus.illegal_op !== 1'b1) $display("FAIL illegal_set: got %b expected 1", bus.illegal_op); else pass_cnt++;
        total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL illegal_bubble: got %b expected 0", bus.ex_valid); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            drive(OP_ADDI, 6'h0, 4'd0, 4'(i), 4'd0); sb.push_back(mk(1'b1, WB_ALU, 4'(i)));
            tick();
            total_cnt++; if (bus.illegal_op !== 1'b1) $display("FAIL illegal_sticky: got %b expected 1 at %0d", bus.illegal_op, i); else pass_cnt++;
            if (bus.wb_valid && sb.size() > 0) begin
                e = sb.pop_front();
                total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                    $display("FAIL illegal_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
            end
        end
        idle();
        rst_n = 1'b0;
        #2;
        total_cnt++; if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.illegal_op} !== 4'b0)
            $display("FAIL async_reset: got %b expected 0000", {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.illegal_op}); else pass_cnt++;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_jal_jr();
        drive(OP_JAL, 6'h0, 4'd0, 4'd0, 4'd0); sb.push_back(mk(1'b1, WB_PC, 4'd15));
        tick();
        total_cnt++; if ({bus.ex_is_jump, bus.ex_sel_j_jr, bus.ex_dst_reg} !== {1'b1, SEL_J, 4'd15})
            $display("FAIL jal_ex: got %0h expected %0h", {bus.ex_is_jump, bus.ex_sel_j_jr, bus.ex_dst_reg}, {1'b1, SEL_J, 4'd15}); else pass_cnt++;
        drive(OP_RTYPE, FN_JR, 4'd2, 4'd0, 4'd9); sb.push_back(mk(1'b0, WB_ALU, 4'd9));
        tick();
        total_cnt++; if ({bus.ex_is_jump, bus.ex_sel_j_jr} !== {1'b1, SEL_JR})
            $display("FAIL jr_ex: got %b expected %b", {bus.ex_is_jump, bus.ex_sel_j_jr}, {1'b1, SEL_JR}); else pass_cnt++;
        idle();
        tick();
        total_cnt++; if ({bus.mem_valid, bus.mem_write_enable, bus.mem_fl_write_enable} !== 3'b100)
            $display("FAIL jr_mem_writes: got %b expected 100", {bus.mem_valid, bus.mem_write_enable, bus.mem_fl_write_enable}); else pass_cnt++;
        if (bus.wb_valid && sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                $display("FAIL jal_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
        end
        for (int k = 0; k < 8 && sb.size() > 0; k++) begin
            tick();
            if (bus.wb_valid) begin
                e = sb.pop_front();
                total_cnt++; if ({bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg} !== {e.we, e.mux, e.dst})
                    $display("FAIL jr_wb: got %0h expected %0h", {bus.wb_reg_write_enable, bus.wb_res_mux, bus.wb_dst_reg}, {e.we, e.mux, e.dst}); else pass_cnt++;
            end
        end
        total_cnt++; if (sb.size() != 0) $display("FAIL jal_jr_drain: got %0d pending expected 0", sb.size()); else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_branch();
        drive(OP_BEQ, 6'h0, 4'd1, 4'd2, 4'd0);
        tick();
        total_cnt++; if ({bus.ex_alu_funct, bus.ex_alu_src} !== {FN_SUB, ALU_SRC_REG})
            $display("FAIL beq_ex: got %0h expected %0h", {bus.ex_alu_funct, bus.ex_alu_src}, {FN_SUB, ALU_SRC_REG}); else pass_cnt++;
        drive(OP_BNE, 6'h0, 4'd1, 4'd2, 4'd0);
        tick();
        total_cnt++; if ({bus.mem_is_branch, bus.mem_sel_beq_bne} !== {1'b1, SEL_BEQ})
            $display("FAIL beq_mem: got %b expected %b", {bus.mem_is_branch, bus.mem_sel_beq_bne}, {1'b1, SEL_BEQ}); else pass_cnt++;
        drive(OP_JT, 6'h0, 4'd0, 4'd0, 4'd0);
        tick();
        total_cnt++; if ({bus.mem_is_branch, bus.mem_sel_beq_bne} !== {1'b1, SEL_BNE})
            $display("FAIL bne_mem: got %b expected %b", {bus.mem_is_branch, bus.mem_sel_beq_bne}, {1'b1, SEL_BNE}); else pass_cnt++;
        drive(OP_JF, 6'h0, 4'd0, 4'd0, 4'd0);
        tick();
        total_cnt++; if ({bus.mem_is_branch, bus.mem_sel_jt_jf, bus.wb_reg_write_enable} !== {1'b1, SEL_JT, 1'b0})
            $display("FAIL jt_mem: got %b expected %b", {bus.mem_is_branch, bus.mem_sel_jt_jf, bus.wb_reg_write_enable}, {1'b1, SEL_JT, 1'b0}); else pass_cnt++;
        idle();
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_no_hazard();
        test_stall();
        test_flush();
        test_illegal();
        test_jal_jr();
        test_branch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipelined, parametrised successor to the LAPI DOpaCA LAMBA combinational control unit. It decodes the instruction in ID into a control word and carries that word through registered EX, MEM and WB stage slices. The block also handles pipeline stalls and flushes, detects load-use hazards, and flags illegal opcodes with a sticky bit. It sits between the IF/ID register and the datapath, and each stage's datapath logic reads control only from its own slice.

## Interface
Parameters:
- `FN_W`, 6, ALU function field width
- `REG_W`, 4, register address width (16 registers)
- `LINK_REG`, 15, destination register for JAL
- `HAZARD_EN`, 1, enables load-use detection; when 0, `id_stall` is tied to 0

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert and active-low; clears all state
- `id_valid`  in  1  ID holds a real instruction
- `id_opcode`  in  6  opcode
- `id_funct`  in  6  R-type funct
- `id_rs`, `id_rt`, `id_rd`  in  REG_W  register fields
- `ex_stall`  in  1  external freeze of all stage slices
- `flush`  in  1  taken jump or branch resolved; kills the younger instructions
- `id_stall`  out  1  load-use hazard; the front end holds PC and IF/ID
- `illegal_op`  out  1  sticky illegal-opcode flag
- `ex_valid`, `ex_alu_src`, `ex_sel_j_jr`, `ex_is_jump`, `ex_is_load`  out  1 each
- `ex_alu_funct`  out  FN_W
- `ex_dst_reg`  out  REG_W  resolved destination number, not a mux select
- `mem_valid`, `mem_write_enable`, `mem_sel_beq_bne`, `mem_fl_write_enable`, `mem_sel_jt_jf`, `mem_is_branch`  out  1 each
- `wb_valid`, `wb_reg_write_enable`  out  1 each
- `wb_res_mux`  out  2
- `wb_dst_reg`  out  REG_W

## Operation
Decode:
- Every control field has a defined default of 0, or `ALU_SRC_IMM` / `WB_ALU`. No field is left unassigned on any path.
- STORE: `mem_write_enable`.
- LOAD: `WB_MEM`, register write, `is_load`.
- J_TYPE: jump, `SEL_J`.
- JAL: jump, `SEL_J`, destination `LINK_REG`, `WB_PC`, register write.
- BEQ / BNE: branch, `ALU_SRC_REG`, `FN_SUB`, `SEL_BEQ` / `SEL_BNE`.
- JT / JF: branch, `SEL_JT` / `SEL_JF`.
- LOADLIT: `WB_IMM`, register write.
- R-type: destination rd, `ALU_SRC_REG`.
  - funct `FN_JR`: jump, `SEL_JR`, no writes.
  - Any other funct: `alu_funct` = funct, register write and flag write.
- ADDI, ANDI, ORI, SLTI, LCL, LCH: destination rt, immediate operand, register write and flag write. `alu_funct` is `FN_ADD`, `FN_AND`, `FN_OR`, `FN_SLT`, `FN_LCL`, `FN_LCH` respectively.
- Any other opcode with `id_valid`=1 is illegal. It enters EX as a bubble and sets `illegal_op`, which stays set until reset.
- Destination rule: rt for I-type, rd for R-type, `LINK_REG` for JAL.

Bubble: all enables 0, valid 0, all fields 0.

Stage advance, evaluated per rising edge:
- If `flush`=1: EX and MEM load bubbles and WB loads MEM. This happens even when `ex_stall`=1 (flush has priority).
- Else if `ex_stall`=1: all slices hold.
- Else:
  - EX loads a bubble if `id_stall` or `!id_valid` or the opcode is illegal; otherwise EX loads the decode.
  - MEM loads EX.
  - WB loads MEM.

Hazard:
- `id_stall` = HAZARD_EN & id_valid & ex_valid & ex_is_load & !flush & (rs_used & rs==ex_dst_reg | rt_used & rt==ex_dst_reg).
- rs_used: every opcode except J_TYPE, JAL, LOADLIT, JT, JF.
- rt_used: R-type, BEQ, BNE, STORE.
- No register is hardwired to zero; r0 compares like any other register.

## Timing
- Reset: every output is 0, including `illegal_op`, all valids and `id_stall`.
- Latency: the decode appears on the EX outputs 1 cycle after the ID edge, on MEM after 2 cycles, on WB after 3 cycles (with no stalls).
- `id_stall` is combinational from the ID inputs and the EX slice, and holds for exactly 1 cycle per load-use pair. The bubble it inserts clears the condition.
- `illegal_op` rises on the edge that captures the illegal instruction. It does not rise if `ex_stall` or `flush` is active on that edge.
- Reset asserted mid-operation clears all slices immediately. The first valid instruction after deassertion decodes normally.

## Structure
- Shared package `lapido_defs` holds the existing OP_/FN_/SEL_/WB_/REG_DST_/ALU_SRC_ constants.
- Add `FN_AND`, `FN_LCL` and `FN_LCH` to `lapido_defs` if absent, plus the control-word field layout.
- Sub-module `ctrl_decode`: pure combinational decode producing the control word, `dst_reg`, rs_used, rt_used and illegal.
- `ctrl_pipeline` holds the three stage slices, the advance logic, the hazard detector and the sticky flag.

## Test plan
- Reset, then ADDI rt=3 → `ex_alu_funct`=`FN_ADD`, `ex_dst_reg`=3 at cycle 1; `wb_reg_write_enable`=1 and `wb_dst_reg`=3 at cycle 3.
- LOAD rt=5 followed by R-type add rs=5 → `id_stall`=1 for 1 cycle and one EX bubble. The add reaches WB one cycle later than without the hazard.
- LOAD rt=5 followed by LOADLIT rt=5 → `id_stall` stays 0.
- Three instructions in flight, then `flush`=1 together with `ex_stall`=1 → `ex_valid`=0 and `mem_valid`=0 on the next edge, and WB takes the old MEM slice.
- Opcode outside the legal set → `illegal_op` rises, EX is a bubble, and the flag stays 1 across 10 further instructions until `rst_n`=0.
- JAL → `ex_sel_j_jr`=`SEL_J`, `wb_dst_reg`=`LINK_REG`, `wb_res_mux`=`WB_PC`. R-type `FN_JR` → `ex_is_jump`=1, `ex_sel_j_jr`=`SEL_JR`, no write enables.
